mult_sequencer: RTL and testbench

- Control and arithmetic stage directly upstream of the shift-register datapath in the 8x8 signed add-shift multiplier.
- Sequences clear/load, eight add-then-shift iterations (subtract on the last), and the final hold.
- Drives the Load/Shift_En strobes of the A, X and B registers.
- Computes the 9-bit sign-extended sum/difference that feeds A's and X's D inputs.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_sequencer_add_sub9.sv | 27 ++
 rtl/mult_sequencer.sv | 122 ++++++++++++
 tb/tb_mult_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the add-shift multiplier sequencer.
//   DEF_WIDTH : default operand width
//   ITER      : add/shift iterations per multiply (one per multiplier bit)
//   state_t   : sequencer state encoding
package mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int ITER      = DEF_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_sequencer_add_sub9.sv
// add_sub9: (WIDTH+1)-bit sign-extending adder/subtractor.
//   A   in  WIDTH    current A register contents
//   S   in  WIDTH    multiplicand
//   Sub in  1        0: A + S, 1: A - S
//   Sum out WIDTH+1  {X_D, A_D}
module add_sub9
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] S,
  input  logic             Sub,
  output logic [WIDTH:0]   Sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;
  logic [WIDTH:0] s_op;

  assign a_ext = {A[WIDTH-1], A};
  assign s_ext = {S[WIDTH-1], S};
  // Two's complement subtract: invert the operand and inject the +1 as carry-in.
  assign s_op  = Sub ? ~s_ext : s_ext;
  assign Sum   = a_ext + s_op + {{WIDTH{1'b0}}, Sub};

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: control and arithmetic stage for the signed add-shift
// multiplier. Sequences clear/load, WIDTH add-then-shift iterations (subtract
// on the last one) and the final hold, and computes the next A/X values.
//   Clk, Reset       clock, synchronous active-high reset
//   Run              start request (level)
//   ClearA_LoadB     IDLE-only request: clear X/A, load B from S
//   S                multiplicand
//   A, M             current A register and B[0]
//   A_D, X_D         next A / X value from the adder
//   Ld_A, Ld_X, Ld_B load strobes
//   Clr_AX           clear of A and X
//   Shift_En         shift strobe for X, A, B
//   Busy             high from START through the last SHIFT
//
// state | meaning
// IDLE  | waiting; ClearA_LoadB clears X/A and loads B, Run starts
// START | clear X/A, reset iteration counter
// ADD   | load A/X with A +/- S when multiplier bit M is set
// SHIFT | arithmetic right shift of X:A:B, advance counter
// DONE  | result held in X:A:B until Run is released
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] A,
  input  logic             M,
  output logic [WIDTH-1:0] A_D,
  output logic             X_D,
  output logic             Ld_A,
  output logic             Ld_X,
  output logic             Ld_B,
  output logic             Clr_AX,
  output logic             Shift_En,
  output logic             Busy
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] K_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [WIDTH:0]  sum9;
  logic            sub;

  // The final iteration weighs the multiplier sign bit, hence the subtract.
  assign sub = (k_q == K_LAST);

  add_sub9 #(.WIDTH(WIDTH)) u_add_sub9 (
    .A   (A),
    .S   (S),
    .Sub (sub),
    .Sum (sum9)
  );

  assign A_D = sum9[WIDTH-1:0];
  assign X_D = sum9[WIDTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    Ld_A     = 1'b0;
    Ld_X     = 1'b0;
    Ld_B     = 1'b0;
    Clr_AX   = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          Ld_B   = 1'b1;
          Clr_AX = 1'b1;
        end else if (Run) begin
          state_d = START;
        end
      end
      START: begin
        Clr_AX  = 1'b1;
        Busy    = 1'b1;
        k_d     = '0;
        state_d = ADD;
      end
      ADD: begin
        Busy    = 1'b1;
        Ld_A    = M;
        Ld_X    = M;
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        // Holding here until Run drops gives one multiply per press.
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: self-checking bench for mult_sequencer with behavioural
// X/A/B shift registers attached. Expected products come from plain signed
// multiplication pushed into a scoreboard; a monitor pops them when the
// sequencer finishes (Busy falls).
module tb_mult_sequencer;

  localparam int W = 8;

  logic         Clk;
  logic         Reset;
  logic         Run;
  logic         ClearA_LoadB;
  logic [W-1:0] S;
  logic [W-1:0] A;
  logic         M;
  logic [W-1:0] A_D;
  logic         X_D;
  logic         Ld_A, Ld_X, Ld_B, Clr_AX, Shift_En, Busy;

  mult_sequencer #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .A            (A),
    .M            (M),
    .A_D          (A_D),
    .X_D          (X_D),
    .Ld_A         (Ld_A),
    .Ld_X         (Ld_X),
    .Ld_B         (Ld_B),
    .Clr_AX       (Clr_AX),
    .Shift_En     (Shift_En),
    .Busy         (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External registers: X shifts in X, A shifts in X, B shifts in A[0].
  logic [W-1:0] ra, rb;
  logic         rx;
  assign A = ra;
  assign M = rb[0];

  always @(posedge Clk) begin
    if (Reset) begin
      ra <= '0;
      rb <= '0;
      rx <= 1'b0;
    end else begin
      if (Ld_B) rb <= S;
      if (Clr_AX) begin
        ra <= '0;
        rx <= 1'b0;
      end else if (Ld_A || Ld_X) begin
        if (Ld_A) ra <= A_D;
        if (Ld_X) rx <= X_D;
      end else if (Shift_En) begin
        ra <= {rx, ra[W-1:1]};
        rb <= {ra[0], rb[W-1:1]};
      end
    end
  end

  typedef struct {
    logic [15:0] prod;
    logic        x;
    int          lda;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [15:0] last_prod;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
    end
  endtask

  // Monitor / scoreboard
  int   busy_cnt = 0, sh_cnt = 0, lda_cnt = 0;
  logic prev_busy = 1'b0;

  always @(negedge Clk) begin
    if (Reset) begin
      busy_cnt  = 0;
      sh_cnt    = 0;
      lda_cnt   = 0;
      prev_busy = 1'b0;
    end else begin
      if (Busy) begin
        check("strobe_exclusive", {30'd0, Ld_A & Shift_En, Ld_A & Clr_AX}, 32'd0);
        if (ClearA_LoadB) check("ldb_while_busy", {31'd0, Ld_B}, 32'd0);
        if (Ld_A) begin
          int ai, si, e;
          logic [8:0] ev;
          ai = $signed(ra);
          si = $signed(S);
          e  = (sh_cnt == W - 1) ? ai - si : ai + si;
          ev = e[8:0];
          check("add_sub_value", {23'd0, X_D, A_D}, {23'd0, ev});
          check("lda_only_when_m", {31'd0, M}, 32'd1);
          lda_cnt++;
        end
        if (Shift_En) sh_cnt++;
        busy_cnt++;
      end
      if (prev_busy && !Busy) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("product_AB", {16'd0, ra, rb}, {16'd0, e.prod});
          check("sign_X", {31'd0, rx}, {31'd0, e.x});
          check("busy_cycles", busy_cnt, 2 * W + 1);
          check("shift_pulses", sh_cnt, W);
          check("lda_pulses", lda_cnt, e.lda);
        end
        busy_cnt = 0;
        sh_cnt   = 0;
        lda_cnt  = 0;
      end
      prev_busy = Busy;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] s, input logic [7:0] b);
    exp_t e;
    int   p;
    p = $signed(s) * $signed(b);
    e.prod = p[15:0];
    e.x    = (p < 0);
    e.lda  = $countones(b);
    sbq.push_back(e);
    last_prod = p[15:0];
  endtask

  // One multiply. reload: load B from S first. hold: minimum cycles Run stays
  // high. midclr: pulse ClearA_LoadB while the operation is running.
  task automatic run_op(input logic [7:0] s, input logic [7:0] b, input bit reload,
                        input int hold, input bit midclr);
    bit started, finished;
    int cyc;
    if (reload) begin
      S = b;
      ClearA_LoadB = 1'b1;
      tick();
      ClearA_LoadB = 1'b0;
    end
    S = s;
    push_exp(s, b);
    Run = 1'b1;
    started  = 0;
    finished = 0;
    for (cyc = 1; cyc <= 120; cyc++) begin
      tick();
      ClearA_LoadB = midclr && (cyc == 5 || cyc == 6);
      if (Busy) begin
        if (finished) check("restart_while_held", 32'd1, 32'd0);
        started = 1;
      end else if (started) begin
        finished = 1;
      end
      if (finished && cyc >= hold) break;
    end
    ClearA_LoadB = 1'b0;
    if (!finished) check("done_timeout", 32'd0, 32'd1);
    Run = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int d0, n;
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    S = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("reset_strobes", {26'd0, Ld_A, Ld_X, Ld_B, Clr_AX, Shift_En, Busy}, 32'd0);
    check("reset_regs", {15'd0, rx, ra, rb}, 32'd0);
    S = 8'h05;
    #1 check("idle_add_pos", {23'd0, X_D, A_D}, 32'h005);
    S = 8'hFB;
    #1 check("idle_add_neg", {23'd0, X_D, A_D}, 32'h1FB);
    tick();

    run_op(8'h02, 8'h03, 1, 0, 0);
    run_op(8'hFE, 8'h03, 1, 0, 0);
    run_op(8'h07, 8'hF9, 1, 0, 0);
    run_op(8'h80, 8'h80, 1, 0, 0);

    d0 = done_cnt;
    run_op(8'h13, 8'h25, 1, 40, 0);
    check("one_mult_per_press", done_cnt - d0, 1);
    check("idle_after_release", {31'd0, Busy}, 32'd0);

    run_op(8'h13, last_prod[7:0], 0, 0, 0);
    run_op(8'h5A, 8'hC3, 1, 0, 1);

    // Reset in the 5th SHIFT cycle.
    S = 8'h6D;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    S = 8'h39;
    Run = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (Shift_En) n++;
      if (n == 5) break;
    end
    check("reach_5th_shift", n, 5);
    Reset = 1'b1;
    Run = 1'b0;
    tick();
    Reset = 1'b0;
    check("after_reset_strobes", {26'd0, Ld_A, Ld_X, Ld_B, Clr_AX, Shift_En, Busy}, 32'd0);
    tick();
    check("after_reset_idle", {31'd0, Busy}, 32'd0);
    run_op(8'h81, 8'h7F, 1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] rs, rbv;
      rs  = 8'($urandom_range(0, 255));
      rbv = 8'($urandom_range(0, 255));
      run_op(rs, rbv, 1, int'($urandom_range(0, 25)), 0);
    end

    check("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
